rv_hazard_ctrl: RTL and testbench

RV_HAZARD_CTRL -- requirements
Module: rv_hazard_ctrl

---
 rtl/rv_cu_pkg.sv | 12 +
 rtl/rv_cu_scoreboard.sv | 95 +++++++++
 rtl/rv_hazard_ctrl.sv | 68 ++++++
 tb/tb_rv_hazard_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_cu_pkg.sv
// Shared types and constants for the RV control-unit hazard logic.
package rv_cu_pkg;

    localparam int GPR_ADDR_W        = 5;
    localparam int IFLIGHT_DEPTH_DEF = 4;

    typedef struct packed {
        logic                  we;
        logic [GPR_ADDR_W-1:0] rd;
    } cu_sb_entry_t;

endpackage

// File: rtl/rv_cu_scoreboard.sv
// In-order scoreboard FIFO of in-flight destination registers with per-source RAW match.
// Optional macro RV_CU_WB_BYPASS_EN: the head entry retiring this cycle is excluded from the match.
module rv_cu_scoreboard
    import rv_cu_pkg::*;
#(
    parameter int DEPTH = IFLIGHT_DEPTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    push,
    input  logic                    push_we,
    input  logic [GPR_ADDR_W-1:0]   push_rd,
    input  logic                    head_pop,
    input  logic                    tail_pop,
    input  logic [GPR_ADDR_W-1:0]   rs1_addr,
    input  logic [GPR_ADDR_W-1:0]   rs2_addr,
    output logic                    rs1_match,
    output logic                    rs2_match,
    output logic [$clog2(DEPTH):0]  cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cu_sb_entry_t     entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] skip;
    logic [PTR_W-1:0] head_q, tail_q, tail_prev;
    logic [CNT_W-1:0] cnt_q;
    logic             hp_eff, tp_eff, push_eff;

    // Pops against an empty FIFO are dropped; a single entry cannot be popped from both ends.
    assign hp_eff    = head_pop & (cnt_q != '0);
    assign tp_eff    = tail_pop & (cnt_q != CNT_W'(hp_eff));
    assign push_eff  = push & ~tp_eff & ((cnt_q != CNT_W'(DEPTH)) | hp_eff);
    assign tail_prev = tail_q - 1'b1;
    assign cnt       = cnt_q;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            if (hp_eff) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            // A push into the slot freed by a same-cycle retire must win, so it comes last.
            if (tp_eff) begin
                valid_q[tail_prev] <= 1'b0;
                tail_q             <= tail_prev;
            end else if (push_eff) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(push_eff) - CNT_W'(hp_eff) - CNT_W'(tp_eff);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff)
            entries_q[tail_q] <= '{we: push_we, rd: push_rd};
    end

    always_comb begin
        skip = '0;
`ifdef RV_CU_WB_BYPASS_EN
        if (hp_eff)
            skip[head_q] = 1'b1;
`endif
    end

    always_comb begin
        rs1_match = 1'b0;
        rs2_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !skip[i] && entries_q[i].we) begin
                if (rs1_addr != '0 && entries_q[i].rd == rs1_addr)
                    rs1_match = 1'b1;
                if (rs2_addr != '0 && entries_q[i].rd == rs2_addr)
                    rs2_match = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (arstn_i) begin
            assert (!(head_pop && cnt_q == '0));
            assert (!(tail_pop && cnt_q == '0));
        end
    end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Fetch/decode stall and kill control built around an in-order RAW scoreboard.
// Optional macro RV_CU_WB_BYPASS_EN (write-through GPR) is handled inside rv_cu_scoreboard.
module rv_hazard_ctrl
    import rv_cu_pkg::*;
#(
    parameter int IFLIGHT_DEPTH = IFLIGHT_DEPTH_DEF
) (
    input  logic                            clk_i,
    input  logic                            arstn_i,
    input  logic                            f_valid_i,
    input  logic [4:0]                      f_cu_rs1_addr_i,
    input  logic [4:0]                      f_cu_rs2_addr_i,
    input  logic                            f_cu_rs1_req_i,
    input  logic                            f_cu_rs2_req_i,
    input  logic [4:0]                      f_cu_rd_addr_i,
    input  logic                            f_cu_rd_we_i,
    input  logic                            d_valid_i,
    input  logic                            d_stall_req_i,
    input  logic                            e_stall_req_i,
    input  logic                            m_stall_req_i,
    input  logic                            e_redirect_i,
    input  logic                            m_retire_i,
    output logic                            cu_stall_f_o,
    output logic                            cu_stall_d_o,
    output logic                            cu_kill_f_o,
    output logic                            cu_kill_d_o,
    output logic [$clog2(IFLIGHT_DEPTH):0]  cu_inflight_cnt_o
);

    localparam int CNT_W = $clog2(IFLIGHT_DEPTH) + 1;

    if ((IFLIGHT_DEPTH < 2) || ((IFLIGHT_DEPTH & (IFLIGHT_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("IFLIGHT_DEPTH must be a power of two, at least 2");
    end

    logic bp, raw, full, issue, tail_pop, rs1_match, rs2_match;

    assign bp       = d_stall_req_i | e_stall_req_i | m_stall_req_i;
    assign raw      = (f_cu_rs1_req_i & rs1_match) | (f_cu_rs2_req_i & rs2_match);
    // A retire in the same cycle frees a slot, so a full scoreboard need not block issue.
    assign full     = (cu_inflight_cnt_o == CNT_W'(IFLIGHT_DEPTH)) & ~m_retire_i;
    assign tail_pop = e_redirect_i & d_valid_i;

    assign cu_stall_d_o = ~arstn_i | bp;
    assign cu_stall_f_o = cu_stall_d_o | raw | full;
    assign cu_kill_f_o  = ~arstn_i | e_redirect_i;
    assign cu_kill_d_o  = cu_kill_f_o;

    assign issue = f_valid_i & ~cu_stall_f_o & ~cu_stall_d_o & ~e_redirect_i;

    rv_cu_scoreboard #(
        .DEPTH (IFLIGHT_DEPTH)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .push      (issue),
        .push_we   (f_cu_rd_we_i),
        .push_rd   (f_cu_rd_addr_i),
        .head_pop  (m_retire_i),
        .tail_pop  (tail_pop),
        .rs1_addr  (f_cu_rs1_addr_i),
        .rs2_addr  (f_cu_rs2_addr_i),
        .rs1_match (rs1_match),
        .rs2_match (rs2_match),
        .cnt       (cu_inflight_cnt_o)
    );

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Self-checking bench for rv_hazard_ctrl: directed scenarios then random traffic vs a queue model.
module tb_rv_hazard_ctrl;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic       we;
        logic [4:0] rd;
    } ent_t;

    logic       clk = 1'b0;
    logic       arstn;
    logic       f_valid, rs1_req, rs2_req, rd_we, d_valid;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic       d_stall, e_stall, m_stall, e_redirect, m_retire;
    logic       stall_f, stall_d, kill_f, kill_d;
    logic [2:0] cnt;

    int   n_assert = 0;
    int   n_fail   = 0;
    ent_t q[$];

    rv_hazard_ctrl #(.IFLIGHT_DEPTH(DEPTH)) dut (
        .clk_i             (clk),
        .arstn_i           (arstn),
        .f_valid_i         (f_valid),
        .f_cu_rs1_addr_i   (rs1_addr),
        .f_cu_rs2_addr_i   (rs2_addr),
        .f_cu_rs1_req_i    (rs1_req),
        .f_cu_rs2_req_i    (rs2_req),
        .f_cu_rd_addr_i    (rd_addr),
        .f_cu_rd_we_i      (rd_we),
        .d_valid_i         (d_valid),
        .d_stall_req_i     (d_stall),
        .e_stall_req_i     (e_stall),
        .m_stall_req_i     (m_stall),
        .e_redirect_i      (e_redirect),
        .m_retire_i        (m_retire),
        .cu_stall_f_o      (stall_f),
        .cu_stall_d_o      (stall_d),
        .cu_kill_f_o       (kill_f),
        .cu_kill_d_o       (kill_d),
        .cu_inflight_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Any in-flight writer of a nonzero source register is a hazard, except a retiring head when write-through.
    function automatic logic raw_of(input logic [4:0] a, input logic req);
        if (!req || a == 5'd0) return 1'b0;
        for (int i = 0; i < q.size(); i++) begin
`ifdef RV_CU_WB_BYPASS_EN
            if (i == 0 && m_retire) continue;
`endif
            if (q[i].we && q[i].rd == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive(input logic fv, input logic [4:0] rd, input logic we,
                         input logic [4:0] a1, input logic q1, input logic [4:0] a2, input logic q2,
                         input logic dv, input logic [2:0] stl, input logic red, input logic ret);
        f_valid = fv; rd_addr = rd; rd_we = we;
        rs1_addr = a1; rs1_req = q1; rs2_addr = a2; rs2_req = q2;
        d_valid = dv; {d_stall, e_stall, m_stall} = stl;
        e_redirect = red; m_retire = ret;
    endtask

    // Check combinational outputs against the model, then advance the model across one clock edge.
    task automatic cycle();
        logic bp, sd, sf, kl, iss;
        bp  = d_stall | e_stall | m_stall;
        sd  = !arstn || bp;
        sf  = sd || raw_of(rs1_addr, rs1_req) || raw_of(rs2_addr, rs2_req) ||
              (q.size() == DEPTH && !m_retire);
        kl  = !arstn || e_redirect;
        iss = f_valid && !sf && !sd && !e_redirect;
        @(negedge clk);
        chk("stall_f", 32'(stall_f), 32'(sf));
        chk("stall_d", 32'(stall_d), 32'(sd));
        chk("kill_f",  32'(kill_f),  32'(kl));
        chk("kill_d",  32'(kill_d),  32'(kl));
        chk("cnt",     32'(cnt),     32'(q.size()));
        if (!arstn) q.delete();
        else begin
            if (m_retire && q.size() > 0) void'(q.pop_front());
            if (e_redirect && d_valid && q.size() > 0) void'(q.pop_back());
            if (iss) q.push_back('{we: rd_we, rd: rd_addr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic fv, input logic [4:0] rd, input logic we,
                        input logic [4:0] a1, input logic q1, input logic [4:0] a2, input logic q2,
                        input logic dv, input logic [2:0] stl, input logic red, input logic ret);
        drive(fv, rd, we, a1, q1, a2, q2, dv, stl, red, ret);
        cycle();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1);
        chk("drain", 32'(cnt), 32'd0);
    endtask

    initial begin
        arstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        @(posedge clk); #1;
        idle();
        idle();
        chk("rst_cnt", 32'(cnt), 32'd0);
        arstn = 1'b1;
        idle();

        // rd=x0 is recorded but never creates a hazard
        step(1, 5'd0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("x0_cnt", 32'(cnt), 32'd1);
        step(1, 5'd5, 1, 0, 0, 5'd0, 1, 0, 3'b000, 0, 0);
        chk("x0_cnt2", 32'(cnt), 32'd2);

        // RAW on x5 held until its entry retires
        step(1, 5'd6, 1, 5'd5, 1, 0, 0, 0, 3'b000, 0, 0);
        chk("raw_stall", 32'(stall_f), 32'd1);
        step(1, 5'd6, 1, 5'd5, 1, 0, 0, 0, 3'b000, 0, 0);
        step(1, 5'd6, 1, 5'd5, 1, 0, 0, 0, 3'b000, 0, 1);
        step(1, 5'd6, 1, 5'd5, 1, 0, 0, 0, 3'b000, 0, 1);
        step(1, 5'd6, 1, 5'd5, 1, 0, 0, 0, 3'b000, 0, 0);
        drain();

        // Fill to capacity, then retire-and-issue in the same cycle
        for (int i = 0; i < DEPTH; i++)
            step(1, 5'(10 + i), 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("full_cnt", 32'(cnt), 32'd4);
        step(1, 5'd20, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("full_cnt2", 32'(cnt), 32'd4);
        step(1, 5'd20, 1, 0, 0, 0, 0, 0, 3'b000, 0, 1);
        chk("full_ret_cnt", 32'(cnt), 32'd4);

        // Redirect + retire at occupancy 2 empties the scoreboard
        step(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1);
        chk("occ2", 32'(cnt), 32'd2);
        step(1, 5'd9, 1, 0, 0, 0, 0, 1, 3'b000, 1, 1);
        chk("redir_cnt", 32'(cnt), 32'd0);

        // Redirect overrides backpressure on the kill outputs
        step(1, 5'd9, 1, 0, 0, 0, 0, 0, 3'b111, 1, 0);

        // Execute backpressure for three cycles freezes issue
        step(1, 5'd3, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 5'd4, 1, 0, 0, 0, 0, 0, 3'b010, 0, 0);
        chk("bp_cnt", 32'(cnt), 32'd1);

        // Reset mid-flight drops all entries and their hazards
        step(1, 5'd7, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        step(1, 5'd8, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("pre_rst_cnt", 32'(cnt), 32'd3);
        arstn = 1'b0;
        step(1, 5'd8, 1, 5'd7, 1, 0, 0, 0, 3'b000, 0, 0);
        arstn = 1'b1;
        chk("post_rst_cnt", 32'(cnt), 32'd0);
        step(1, 5'd1, 1, 5'd7, 1, 5'd3, 1, 0, 3'b000, 0, 0);
        chk("post_rst_nohaz", 32'(cnt), 32'd1);

        // Random traffic within the retire/redirect protocol
        for (int n = 0; n < 600; n++) begin
            logic ret, red, dv;
            ret = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            red = ($urandom_range(0, 9) == 0);
            dv  = red && (q.size() > (ret ? 1 : 0)) && ($urandom_range(0, 1) == 1);
            arstn = ($urandom_range(0, 149) != 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                  dv, {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0},
                  red, ret);
            cycle();
        end
        arstn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
